muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit, downstream of the register file. Consumes
//  rs1/rs2 operands plus funct3 and the destination index. Returns a result with
//  rd/rd_write for register-file writeback. Multi-cycle; the core stalls issue
//  while busy is high.
// PARAMETERS
//  XLEN    32  operand/result width
//  RD_W    5   destination register index width
// PORTS
//  clk       in   1      single clock, rising edge
//  reset     in   1      synchronous, active-high
//  start     in   1      request; accepted only when busy==0
//  funct3    in   3      000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  rs1       in   XLEN   signed operand A (dividend / multiplicand)
//  rs2       in   XLEN   signed operand B (divisor / multiplier)
//  rd_in     in   RD_W   destination index, latched at accept
//  busy      out  1      high from the cycle after accept through the done cycle
//  done      out  1      one-cycle pulse: result valid
//  result    out  XLEN   result; held stable from done until the next done
//  rd        out  RD_W   latched rd_in; valid with done
//  rd_write  out  1      equals done; drives register-file write enable
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, rd_write=0; result=0; rd=0; internal regs cleared.
//  - Accept: edge where start && state==IDLE. Latch funct3, rs1, rs2, rd_in.
//    Take operand magnitudes per signedness.
//  - States: IDLE -> CALC (32 cycles, counter 31..0) -> FIX -> DONE -> IDLE.
//  - CALC, multiply: radix-2 shift-add on the 64-bit product.
//  - CALC, divide: restoring shift-subtract, 1 quotient bit per cycle.
//  - FIX: apply sign correction (2's complement of product / quotient / remainder),
//    then select low or high word.
//  - DONE: done=rd_write=1 for exactly one cycle; result/rd registered.
//  - Nominal latency: done is high on the 34th cycle after the accept edge.
//  - MULH signed x signed; MULHSU signed rs1 x unsigned rs2; MULHU unsigned x unsigned.
//  - MUL returns the low 32 bits, identical for any signedness.
//  - Divide by zero (rs2==0): DIV/DIVU -> 32'hFFFF_FFFF; REM/REMU -> rs1.
//  - Signed overflow (DIV, rs1=32'h8000_0000, rs2=-1): quotient 32'h8000_0000; REM -> 0.
//  - Both special cases bypass CALC/FIX: IDLE -> DONE, so done is high 1 cycle after accept.
//  - start while busy: ignored, no queuing. start in the DONE cycle: ignored.
//    Earliest re-accept is the cycle after done.
//  - Operand inputs may change after accept without effect.
//  - Reset mid-operation: abort to IDLE next edge; no done pulse for the aborted op.
//  - Register file gates its reads while rd_write=1. The core must not sample
//    operands in the done cycle.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined:
//   - MUL/MULH/MULHSU/MULHU use a 33x33 signed DSP product, registered once.
//   - Path is IDLE -> FIX -> DONE; done is high 2 cycles after accept.
//   - Divides are unchanged.
//  Undefined: all multiplies use the iterative path, 34-cycle latency. No DSP inferred.
// STRUCTURE
//  - muldiv_pkg: funct3 opcode localparams, state encoding (IDLE/CALC/FIX/DONE),
//    XLEN default, special-case constants (DIV0_Q=all-ones, INT_MIN).
//  - Sub-module muldiv_shift_core: one radix-2 step (add/sub, shift, quotient bit)
//    on {acc,hi,lo}. muldiv_unit holds the FSM, counter, sign fix-up and result mux.
// TESTING
//  - MUL 7 x -3 -> result=32'hFFFF_FFEB (-21), done 34 cycles after accept,
//    rd_write=1 one cycle, rd echoes rd_in.
//  - MULHU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> 32'hFFFF_FFFE.
//    MULH -1 x -1 -> 0. MULHSU -1 x 2 -> 32'hFFFF_FFFF.
//  - DIV -7 / 2 -> -3 (32'hFFFF_FFFD). REM -7 / 2 -> -1. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
//  - DIV 5 / 0 -> 32'hFFFF_FFFF; REMU 5 / 0 -> 5; DIV 32'h8000_0000 / -1 -> 32'h8000_0000;
//    REM -> 0; each done 1 cycle after accept.
//  - start pulsed every cycle with changing operands during an op -> only the first
//    accepted; one done; result matches the first operands.
//  - reset asserted at cycle 10 of a DIV -> busy=0 next cycle; no done; a fresh op
//    afterwards completes correctly. Rerun the suite with MULDIV_FAST_MUL_EN:
//    MUL latency = 2.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared opcodes, FSM encoding and special-case constants for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned RD_W_DEF = 5;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [XLEN_DEF-1:0] DIV0_Q  = '1;
  localparam logic [XLEN_DEF-1:0] INT_MIN = {1'b1, {(XLEN_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } state_e;

  function automatic logic rs1_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_shift_core.sv
// One radix-2 step on {acc,lo}: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_shift_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_acc,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_opnd,
  output logic [XLEN-1:0] o_acc,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;
  logic            w_qbit;

  always_comb begin
    w_sum   = {1'b0, i_acc} + (i_lo[0] ? {1'b0, i_opnd} : '0);
    w_shift = {i_acc, i_lo[XLEN-1]};
    w_qbit  = (w_shift >= {1'b0, i_opnd});
    // The true difference is below 2^XLEN whenever it is kept, so the low word suffices.
    w_diff  = w_shift[XLEN-1:0] - i_opnd;
    if (i_is_div) begin
      o_acc = w_qbit ? w_diff : w_shift[XLEN-1:0];
      o_lo  = {i_lo[XLEN-2:0], w_qbit};
    end else begin
      o_acc = w_sum[XLEN:1];
      o_lo  = {w_sum[0], i_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with registered writeback outputs.
// Define MULDIV_FAST_MUL_EN to route multiplies through a single registered 33x33 product.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned RD_W = RD_W_DEF
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [RD_W-1:0] i_rd_in,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic [RD_W-1:0] o_rd,
  output logic            o_rd_write
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [XLEN-1:0] DivZeroQ = XLEN'(DIV0_Q);
  localparam logic [XLEN-1:0] IntMin   = XLEN'(INT_MIN);

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic [2:0]      r_f3;
  logic [XLEN-1:0] r_acc, r_lo, r_opnd, r_result;
  logic [RD_W-1:0] r_rd;
  logic            r_neg_q, r_neg_r, r_done;

  logic            w_is_div, w_s1, w_s2, w_div0, w_ovf;
  logic [XLEN-1:0] w_mag1, w_mag2, w_special, w_acc_nxt, w_lo_nxt;
  logic [XLEN-1:0] w_quo, w_rem, w_fix_res;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;

  always_comb begin
    w_is_div  = i_funct3[2];
    w_s1      = rs1_signed(i_funct3) & i_rs1[XLEN-1];
    w_s2      = rs2_signed(i_funct3) & i_rs2[XLEN-1];
    w_mag1    = w_s1 ? -i_rs1 : i_rs1;
    w_mag2    = w_s2 ? -i_rs2 : i_rs2;
    w_div0    = w_is_div && (i_rs2 == '0);
    w_ovf     = w_is_div && !i_funct3[0] && (i_rs1 == IntMin) && (i_rs2 == '1);
    if (w_div0) w_special = i_funct3[1] ? i_rs1 : DivZeroQ;
    else        w_special = i_funct3[1] ? '0 : IntMin;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     w_fa, w_fb;
  logic signed [2*XLEN-1:0] w_fprod;

  always_comb begin
    w_fa    = {rs1_signed(i_funct3) & i_rs1[XLEN-1], i_rs1};
    w_fb    = {rs2_signed(i_funct3) & i_rs2[XLEN-1], i_rs2};
    w_fprod = (2*XLEN)'(w_fa) * (2*XLEN)'(w_fb);
  end
`endif

  muldiv_shift_core #(
    .XLEN (XLEN)
  ) u_shift_core (
    .i_is_div (r_f3[2]),
    .i_acc    (r_acc),
    .i_lo     (r_lo),
    .i_opnd   (r_opnd),
    .o_acc    (w_acc_nxt),
    .o_lo     (w_lo_nxt)
  );

  always_comb begin
    w_prod     = {r_acc, r_lo};
    w_prod_fix = r_neg_q ? -w_prod : w_prod;
    w_quo      = r_neg_q ? -r_lo : r_lo;
    w_rem      = r_neg_r ? -r_acc : r_acc;
    w_fix_res  = '0;
    unique case (r_f3)
      F3_MUL:                         w_fix_res = w_prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:   w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:                w_fix_res = w_quo;
      F3_REM, F3_REMU:                w_fix_res = w_rem;
      default:                        w_fix_res = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_f3     <= '0;
      r_acc    <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_result <= '0;
      r_rd     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_f3    <= i_funct3;
            r_rd    <= i_rd_in;
            r_cnt   <= CntW'(XLEN - 1);
            r_neg_q <= w_s1 ^ w_s2;
            r_neg_r <= w_s1;
            if (w_div0 || w_ovf) begin
              r_result <= w_special;
              r_done   <= 1'b1;
              r_state  <= StDone;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!w_is_div) begin
              // Product is already signed-correct; skip the negation in FIX.
              r_acc   <= w_fprod[2*XLEN-1:XLEN];
              r_lo    <= w_fprod[XLEN-1:0];
              r_neg_q <= 1'b0;
              r_state <= StFix;
`endif
            end else begin
              // Divide: lo holds the dividend; multiply: lo holds the multiplier.
              r_acc   <= '0;
              r_lo    <= w_is_div ? w_mag1 : w_mag2;
              r_opnd  <= w_is_div ? w_mag2 : w_mag1;
              r_state <= StCalc;
            end
          end
        end
        StCalc: begin
          r_acc <= w_acc_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= StFix;
        end
        StFix: begin
          r_result <= w_fix_res;
          r_done   <= 1'b1;
          r_state  <= StDone;
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy     = (r_state != StIdle);
  assign o_done     = r_done;
  assign o_rd_write = r_done;
  assign o_result   = r_result;
  assign o_rd       = r_rd;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 2;
`else
  localparam int MulLat = 34;
`endif
  localparam int DivLat = 34;
  localparam int SpcLat = 1;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2, result;
  logic [4:0]  rd_in, rd;
  logic        busy, done, rd_write;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_unit u_dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (start),
    .i_funct3   (funct3),
    .i_rs1      (rs1),
    .i_rs2      (rs2),
    .i_rd_in    (rd_in),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result),
    .o_rd       (rd),
    .o_rd_write (rd_write)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble operands after accept, then check latency, result and writeback.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp,
                        input int lat);
    int   n;
    logic seen;
    @(negedge clk);
    start = 1'b1; funct3 = f3; rs1 = a; rs2 = b; rd_in = r;
    @(posedge clk);
    #1;
    start = 1'b0; rs1 = $urandom; rs2 = $urandom; rd_in = ~r;
    n = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (n == 1) check_eq({tag, ".busy"}, 32'(busy), 32'd1);
      if (done) seen = 1'b1;
    end
    check_eq({tag, ".lat"}, n, lat);
    check_eq({tag, ".res"}, result, exp);
    check_eq({tag, ".rd"}, 32'(rd), 32'(r));
    check_eq({tag, ".wr"}, 32'(rd_write), 32'd1);
    @(negedge clk);
    check_eq({tag, ".pulse"}, 32'(done), 32'd0);
    check_eq({tag, ".idle"}, 32'(busy), 32'd0);
    check_eq({tag, ".hold"}, result, exp);
  endtask

  initial begin
    int n;
    int dones;
    reset = 1'b1; start = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0; rd_in = '0;
    repeat (3) @(negedge clk);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.done", 32'(done), 32'd0);
    check_eq("rst.wr", 32'(rd_write), 32'd0);
    check_eq("rst.res", result, 32'd0);
    check_eq("rst.rd", 32'(rd), 32'd0);
    reset = 1'b0;

    run_op("mul",     F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, MulLat);
    run_op("mul2",    F3_MUL,    32'h1234_5678,  32'h0000_0010, 5'd2,  32'h2345_6780, MulLat);
    run_op("mulhu",   F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, MulLat);
    run_op("mulh",    F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'h0000_0000, MulLat);
    run_op("mulhmin", F3_MULH,   INT_MIN,        INT_MIN,       5'd5,  32'h4000_0000, MulLat);
    run_op("mulhsu",  F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd6,  32'hFFFF_FFFF, MulLat);
    run_op("div",     F3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFD, DivLat);
    run_op("rem",     F3_REM,    32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFF, DivLat);
    run_op("div_n",   F3_DIV,    32'd7,          32'hFFFF_FFFE, 5'd9,  32'hFFFF_FFFD, DivLat);
    run_op("rem_n",   F3_REM,    32'd7,          32'hFFFF_FFFE, 5'd10, 32'h0000_0001, DivLat);
    run_op("divu",    F3_DIVU,   32'd100,        32'd7,         5'd11, 32'd14,        DivLat);
    run_op("remu",    F3_REMU,   32'd100,        32'd7,         5'd12, 32'd2,         DivLat);
    run_op("divu_big",F3_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'd0,         DivLat);
    run_op("remu_big",F3_REMU,   32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'h8000_0000, DivLat);
    run_op("div0",    F3_DIV,    32'd5,          32'd0,         5'd15, DIV0_Q,        SpcLat);
    run_op("remu0",   F3_REMU,   32'd5,          32'd0,         5'd16, 32'd5,         SpcLat);
    run_op("divovf",  F3_DIV,    INT_MIN,        32'hFFFF_FFFF, 5'd17, INT_MIN,       SpcLat);
    run_op("removf",  F3_REM,    INT_MIN,        32'hFFFF_FFFF, 5'd18, 32'd0,         SpcLat);

    // start held high with changing operands while busy: only the first op counts.
    @(negedge clk);
    start = 1'b1; funct3 = F3_DIVU; rs1 = 32'd100; rs2 = 32'd7; rd_in = 5'd19;
    @(posedge clk);
    n = 0; dones = 0;
    while (dones == 0 && n < 60) begin
      @(negedge clk);
      n++;
      if (done) begin
        dones++;
        start = 1'b0;
      end else begin
        funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom; rd_in = 5'($urandom);
      end
    end
    check_eq("spam.lat", n, DivLat);
    check_eq("spam.res", result, 32'd14);
    check_eq("spam.rd", 32'(rd), 32'd19);
    start = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_eq("spam.dones", dones, 1);
    check_eq("spam.idle", 32'(busy), 32'd0);

    // Reset in the middle of a divide aborts it without a done pulse.
    @(negedge clk);
    start = 1'b1; funct3 = F3_DIV; rs1 = 32'd100; rs2 = 32'd7; rd_in = 5'd20;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort.busy", 32'(busy), 32'd0);
    check_eq("abort.done", 32'(done), 32'd0);
    check_eq("abort.res", result, 32'd0);
    reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_eq("abort.dones", dones, 0);
    run_op("after", F3_DIV, 32'hFFFF_FF9C, 32'd7, 5'd21, 32'hFFFF_FFF2, DivLat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
